// File: rtl/logic_result_fifo.sv
// logic_result_fifo: output-side buffer behind the pipelined logic unit.
// Absorbs the unit's unthrottled result stream and hands words to a consumer
// over valid/ready. Raises almost_full early enough for the issuer to stop
// before data can be lost. Words arriving with no free slot are dropped, and a
// sticky overflow flag records the loss.
//
// Ports:
//   clk, rst          - clock; asynchronous active-high reset
//   v_in, d_in        - result valid/data from the logic unit (no backpressure)
//   m_valid, m_data   - head word to consumer; m_data is 0 while m_valid=0
//   m_ready           - consumer accepts the head word
//   count             - occupancy, 0..DEPTH
//   almost_full       - count >= DEPTH-AFULL_MARGIN
//   overflow          - sticky flag: a valid word was dropped
//   clr_overflow      - synchronous clear of overflow (a same-cycle drop wins)
module logic_result_fifo #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AFULL_MARGIN = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     v_in,
  input  logic [WIDTH-1:0]         d_in,
  output logic                     m_valid,
  output logic [WIDTH-1:0]         m_data,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int unsigned PW          = $clog2(DEPTH);
  localparam int unsigned CW          = PW + 1;
  localparam int unsigned AFULL_LEVEL = DEPTH - AFULL_MARGIN;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;

  logic             push, pop, drop;

  // Handshake decode, pointer/occupancy/flag next-state.
  always_comb begin
    pop      = valid_q & m_ready;
    // A pop at full frees the slot this edge, so the incoming word still fits.
    push     = v_in & ((count_q != CW'(DEPTH)) | pop);
    drop     = v_in & ~push;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (drop)              ovf_d = 1'b1;
    else if (clr_overflow) ovf_d = 1'b0;

    valid_d = (count_d != CW'(0));
    afull_d = (count_d >= CW'(AFULL_LEVEL));

    // Registered head: the next head is the word being written this edge when
    // the read pointer lands on the current write slot (empty, or one entry
    // popped while pushing); otherwise it is already in the array.
    head_d = '0;
    if (valid_d) begin
      if (push && (rd_ptr_d == wr_ptr_q)) head_d = d_in;
      else                                head_d = mem[rd_ptr_d];
    end
  end

  // Control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= d_in;
  end

  assign m_valid     = valid_q;
  assign m_data      = head_q;
  assign count       = count_q;
  assign almost_full = afull_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/logic_result_fifo.md
# logic_result_fifo

Output-side buffer placed directly downstream of the pipelined logic unit. It captures every valid result word the unit emits; the unit has no backpressure, so this block absorbs the stream. It presents the words to a consumer over a valid/ready handshake and raises `almost_full` early enough for the operand issuer to stop before data can be lost. Words that arrive with no free slot are dropped, and a sticky `overflow` flag records the loss.

## Interface
- `WIDTH`, 32: result word width; must match the logic unit's `WIDTH`.
- `DEPTH`, 8: number of entries; power of two, minimum 4.
- `AFULL_MARGIN`, 3: free-slot threshold for `almost_full`; must be less than `DEPTH`. The default covers 2 cycles of logic-unit latency plus 1 cycle of issuer reaction.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `v_in` input 1: result valid, driven by the logic unit's `v_out`.
- `d_in` input WIDTH: result data, driven by the logic unit's `out`.
- `m_valid` output 1: FIFO holds at least one word.
- `m_data` output WIDTH: head word; forced to 0 while `m_valid`=0.
- `m_ready` input 1: consumer accepts the head word.
- `count` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `almost_full` output 1: `count` >= DEPTH-AFULL_MARGIN.
- `overflow` output 1: sticky; set when a valid word was dropped.
- `clr_overflow` input 1: synchronous clear of `overflow`.

## Operation
- Storage: DEPTH x WIDTH register array, write pointer `wr_ptr`, read pointer `rd_ptr`, and occupancy `count`. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- `pop` = `m_valid` & `m_ready`.
- `push` = `v_in` & (`count` != DEPTH | `pop`).
  - When full, a simultaneous pop frees the slot and the incoming word is accepted.
- On `push`: write `d_in` to `mem[wr_ptr]` and increment `wr_ptr`.
- On `pop`: increment `rd_ptr`.
- Count update:
  - push only: `count` + 1.
  - pop only: `count` - 1.
  - both or neither: `count` unchanged.
- `drop` = `v_in` & ~`push`, which can occur only when `count` = DEPTH with no pop. The word is discarded and the pointers and `count` are untouched.
- `overflow` next state:
  - set on `drop`;
  - otherwise clear on `clr_overflow`;
  - otherwise hold.
  - If `drop` and `clr_overflow` occur in the same cycle, set wins.
- `m_valid` = (`count` != 0). `m_data` = `m_valid` ? `mem[rd_ptr]` : 0.
- `almost_full` is decoded from the registered `count`; no combinational path from `v_in` or `m_ready`.
- A consumer holding `m_valid`=1 with `m_ready`=0 sees a stable `m_data`. Pushes to the tail never disturb the head.
- The memory array is not reset. All control state is reset.

## Timing
- Reset values (asynchronous, immediate on `rst`=1):
  - `m_valid`=0, `m_data`=0, `count`=0, `almost_full`=0, `overflow`=0;
  - `wr_ptr`=`rd_ptr`=0.
- Reset mid-operation discards all buffered words. The first edge after `rst` deasserts behaves as the empty state.
- Write-to-read latency is 1 cycle. A word pushed into an empty FIFO at edge N has `m_valid`=1 and `m_data`=word after edge N. It can be popped at edge N+1.
- Pop takes effect at the edge where `m_valid` & `m_ready`. The next word, or `m_valid`=0, appears after that edge.
- Sustained throughput is one push and one pop per cycle, at any occupancy including full.
- `almost_full` updates 1 cycle after the push or pop that crosses the threshold.
  - With the defaults it asserts at `count`=5.
  - An issuer that stops within 1 cycle of seeing it leaves at most 2 words in flight and loses none.
- `overflow` asserts the cycle after the dropping edge and stays high until cleared or reset.
- `clr_overflow` takes effect at the next edge.

## Test plan
- **Reset.** Assert `rst` mid-stream with `count`=5 → outputs immediately go to `m_valid`=0, `m_data`=0, `count`=0, `almost_full`=0, `overflow`=0. After release, a push of 0xA5A5A5A5 appears on `m_data` 1 cycle later.
- **Fill and drain in order.** Push 0x00000001..0x00000008 back-to-back with `m_ready`=0:
  - `count` steps 1..8;
  - `almost_full` rises when `count` reaches 5;
  - `overflow` stays 0.
  - Then hold `m_ready`=1 → words pop out in order, 1 per cycle, and `m_valid` falls after the 8th.
- **Overflow.** With FIFO full (8 words) and `m_ready`=0, push 0xDEADBEEF → it is dropped, `count` stays 8, and `overflow`=1 the next cycle. Drain all 8 → 0xDEADBEEF never appears. Pulse `clr_overflow` → `overflow`=0.
- **Full with simultaneous push and pop.** With `count`=8, `v_in`=1 and `m_ready`=1 for 20 cycles → `count` holds at 8, no drops, and the output sequence equals the input sequence.
- **Clear collision.** Assert `clr_overflow` in the same cycle as a drop → `overflow` remains 1.
- **Random soak.** Connect behind the logic unit, run 10k random opcode/operand beats with random `m_ready` at 30% duty, and have the issuer honour `almost_full` → `overflow` is never set and a scoreboard matches every result in order.
